// File: rtl/riscv_divider.sv
// Iterative radix-2 divider for RV64M DIV/DIVU/REM/REMU and their *W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
// The final result is registered on the edge that enters DONE, so valid and
// result are both visible during the single DONE cycle.
module riscv_divider #(
  parameter int unsigned width = 64
) (
  input  logic             i_riscv_div_clk,
  input  logic             i_riscv_div_rst,
  input  logic             i_riscv_div_start,
  input  logic [1:0]       i_riscv_div_op,
  input  logic             i_riscv_div_word,
  input  logic [width-1:0] i_riscv_div_rs1,
  input  logic [width-1:0] i_riscv_div_rs2,
  input  logic             i_riscv_div_kill,
  output logic             o_riscv_div_busy,
  output logic             o_riscv_div_valid,
  output logic [width-1:0] o_riscv_div_result
);

  localparam int unsigned CntW = $clog2(width + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             word_q, word_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [width-1:0] rem_q, rem_d;
  logic [width-1:0] quo_q, quo_d;
  logic [width-1:0] divisor_q, divisor_d;
  logic [width-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  // Operand forming
  logic             is_signed;
  logic [width-1:0] a_ext, b_ext, a_abs, b_abs;
  logic             sign_a, sign_b;
  logic             div_zero, overflow;
  logic [width-1:0] special_res;
  logic [width-1:0] quo_init;

  // Iteration datapath
  logic [width:0]   rem_sh;
  logic [width+1:0] diff;
  logic             ge;
  logic [width-1:0] rem_nx, quo_nx;
  logic [width-1:0] final_res;
  logic             unused_diff;

  function automatic logic [width-1:0] sext_w(input logic w, input logic [width-1:0] v);
    if (w) return {{(width - 32){v[31]}}, v[31:0]};
    return v;
  endfunction

  // Decode incoming operands: extend word operands, take magnitudes, detect early-out cases
  always_comb begin
    is_signed = ~i_riscv_div_op[0];
    if (i_riscv_div_word) begin
      a_ext = {{(width - 32){is_signed & i_riscv_div_rs1[31]}}, i_riscv_div_rs1[31:0]};
      b_ext = {{(width - 32){is_signed & i_riscv_div_rs2[31]}}, i_riscv_div_rs2[31:0]};
      overflow = is_signed && (i_riscv_div_rs1[31:0] == 32'h8000_0000)
                 && (i_riscv_div_rs2[31:0] == 32'hFFFF_FFFF);
    end else begin
      a_ext = i_riscv_div_rs1;
      b_ext = i_riscv_div_rs2;
      overflow = is_signed && (i_riscv_div_rs1 == {1'b1, {(width - 1){1'b0}}})
                 && (&i_riscv_div_rs2);
    end
    sign_a   = is_signed & a_ext[width-1];
    sign_b   = is_signed & b_ext[width-1];
    a_abs    = sign_a ? -a_ext : a_ext;
    b_abs    = sign_b ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    special_res = '0;
    if (div_zero) begin
      special_res = i_riscv_div_op[1] ? a_ext : {width{1'b1}};
    end else if (overflow) begin
      special_res = i_riscv_div_op[1] ? '0 : a_ext;
    end
    // Word dividends sit in the top half so 32 shifts move every bit through rem
    quo_init = i_riscv_div_word ? (a_abs << (width - 32)) : a_abs;
  end

  // One restoring-division step plus sign correction of the step's outcome
  always_comb begin
    rem_sh      = {rem_q, quo_q[width-1]};
    diff        = {1'b0, rem_sh} - {2'b00, divisor_q};
    ge          = ~diff[width+1];
    unused_diff = diff[width];
    rem_nx      = ge ? diff[width-1:0] : rem_sh[width-1:0];
    quo_nx      = {quo_q[width-2:0], ge};
    if (op_q[1]) begin
      final_res = (~op_q[0] & neg_rem_q) ? -rem_nx : rem_nx;
    end else begin
      final_res = (~op_q[0] & neg_quo_q) ? -quo_nx : quo_nx;
    end
    final_res = sext_w(word_q, final_res);
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and datapath registers
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    if (i_riscv_div_kill) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_riscv_div_start) begin
            op_d      = i_riscv_div_op;
            word_d    = i_riscv_div_word;
            neg_quo_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            if (div_zero || overflow) begin
              result_d = sext_w(i_riscv_div_word, special_res);
              valid_d  = 1'b1;
              state_d  = StDone;
            end else begin
              cnt_d     = i_riscv_div_word ? CntW'(32) : CntW'(width);
              rem_d     = '0;
              quo_d     = quo_init;
              divisor_d = b_abs;
              state_d   = StBusy;
            end
          end
        end
        StBusy: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            result_d = final_res;
            valid_d  = 1'b1;
            state_d  = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_riscv_div_clk) begin
    if (i_riscv_div_rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      word_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      word_q    <= word_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign o_riscv_div_busy   = (state_q != StIdle);
  assign o_riscv_div_valid  = valid_q;
  assign o_riscv_div_result = result_q;

endmodule

// File: tb/tb_riscv_divider.sv
// Directed-vector bench for riscv_divider: latency, results, early-outs, kill and reset.
module tb_riscv_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        word;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        kill;
  logic        busy;
  logic        valid;
  logic [63:0] result;

  int n_checks;
  int n_fail;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  riscv_divider #(.width(64)) u_dut (
    .i_riscv_div_clk   (clk),
    .i_riscv_div_rst   (rst),
    .i_riscv_div_start (start),
    .i_riscv_div_op    (op),
    .i_riscv_div_word  (word),
    .i_riscv_div_rs1   (rs1),
    .i_riscv_div_rs2   (rs2),
    .i_riscv_div_kill  (kill),
    .o_riscv_div_busy  (busy),
    .o_riscv_div_valid (valid),
    .o_riscv_div_result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Drive start for one cycle; returns in cycle k+1 where k is the accepting edge
  task automatic start_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    word  = w;
    rs1   = a;
    rs2   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one op, measure cycles from acceptance to valid, check result and busy window.
  // inj > 0 pulses start with unrelated operands in cycle k+inj.
  task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat, input int inj);
    int   lat;
    logic got;
    logic busy_ok;
    start_op(o, w, a, b);
    lat     = 1;
    got     = 1'b0;
    busy_ok = 1'b1;
    while (!got && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (valid) begin
        got = 1'b1;
      end else begin
        if (inj > 0) begin
          if (lat == inj) begin
            start = 1'b1;
            op    = OpRemu;
            word  = 1'b1;
            rs1   = 64'd50;
            rs2   = 64'd3;
          end else begin
            start = 1'b0;
          end
        end
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_res"}, result, exp);
    check_val({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
    @(negedge clk);
    check_val({tag, "_idle"}, {62'd0, busy, valid}, 64'd0);
  endtask

  initial begin
    logic seen_valid;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    word  = 1'b0;
    rs1   = '0;
    rs2   = '0;
    kill  = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", {62'd0, busy, valid}, 64'd0);
    check_val("reset_res", result, 64'd0);
    rst = 1'b0;

    run_op("divu", OpDivu, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
    run_op("remu", OpRemu, 1'b0, 64'd100, 64'd7, 64'd2, 65, 0);
    run_op("div_neg", OpDiv, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem_neg", OpRem, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("rem_pos", OpRem, 1'b0, 64'd7, -64'sd2, 64'd1, 65, 0);
    run_op("divu_z", OpDivu, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem_z", OpRem, 1'b0, -64'sd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF7, 1, 0);
    run_op("div_ovf", OpDiv, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf", OpRem, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 1, 0);
    run_op("divw", OpDiv, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hDEAD_0000_0000_0002,
           64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
    run_op("divuw", OpDivu, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    run_op("divw_ovf", OpDiv, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("busy_start", OpDivu, 1'b0, 64'd100, 64'd7, 64'd14, 65, 5);

    // Kill sampled at edge k+10
    start_op(OpDivu, 1'b0, 64'd1000, 64'd3);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_val("kill_outs", {62'd0, busy, valid}, 64'd0);
    seen_valid = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (valid) seen_valid = 1'b1;
    end
    check_val("kill_novalid", {63'd0, seen_valid}, 64'd0);
    check_val("kill_res", result, 64'd14);

    // Reset sampled at edge k+20
    start_op(OpDivu, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_outs", {62'd0, busy, valid}, 64'd0);
    check_val("rst_res", result, 64'd0);

    run_op("after_rst", OpRemu, 1'b0, 64'd1000, 64'd3, 64'd1, 65, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
